// File: rtl/uart_tx.sv
// uart_tx: serializes one parallel word per frame onto an idle-high UART line
// (start, DATA_BITS data LSB-first, optional parity, STOP_BITS stop bits).
// tx is a flop output so it can feed the preset-style pad output register.
module uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,   // 0 none, 1 odd, 2 even
  parameter int STOP_BITS    = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_BITS-1:0] in_data,
  output logic                 tx,
  output logic                 busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  state_t               r_state, w_state_nxt;
  logic [CW-1:0]        r_cnt, w_cnt_nxt;
  logic [BW-1:0]        r_idx, w_idx_nxt;      // data bit index, reused as stop bit index
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic [DATA_BITS-1:0] r_data, w_data_nxt;    // untouched copy of the word, for parity
  logic                 r_tx, w_tx_nxt;
  logic                 w_bit_end;
  logic                 w_par;

  assign in_ready  = (r_state == S_IDLE) && !reset;
  assign busy      = (r_state != S_IDLE);
  assign tx        = r_tx;
  assign w_bit_end = (r_cnt == CNT_LAST);
  // Even parity bit is the XOR of the word; odd parity inverts it.
  assign w_par     = (^r_data) ^ (PARITY == 1);

  // Next-state, counters, shifter, and the line value for the next cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_data;
    w_tx_nxt    = 1'b1;
    if (r_state != S_IDLE) w_cnt_nxt = w_bit_end ? '0 : r_cnt + 1'b1;
    case (r_state)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          w_state_nxt = S_START;
          w_shift_nxt = in_data;
          w_data_nxt  = in_data;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
        end
      end
      S_START: if (w_bit_end) w_state_nxt = S_DATA;
      S_DATA: begin
        if (w_bit_end) begin
          w_shift_nxt = r_shift >> 1;
          if (r_idx == DATA_LAST) begin
            w_idx_nxt   = '0;
            w_state_nxt = (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      S_PAR: if (w_bit_end) w_state_nxt = S_STOP;
      S_STOP: begin
        if (w_bit_end) begin
          if (r_idx == STOP_LAST) begin
            w_idx_nxt   = '0;
            w_state_nxt = S_IDLE;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // tx is registered, so it is derived from where the FSM is going.
    case (w_state_nxt)
      S_START: w_tx_nxt = 1'b0;
      S_DATA:  w_tx_nxt = w_shift_nxt[0];
      S_PAR:   w_tx_nxt = w_par;
      default: w_tx_nxt = 1'b1;
    endcase
  end

  // State and datapath registers; reset aborts any frame and parks the line high.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_data  <= w_data_nxt;
      r_tx    <= w_tx_nxt;
    end
  end
endmodule
